// File: rtl/nrisc_pkg.sv
// Shared nRISC definitions: default data-bus widths, read-owner encoding and
// the DMA starvation counter width and update rule.
package nrisc_pkg;

  localparam int unsigned NRISC_ADDR_W = 16;
  localparam int unsigned NRISC_DATA_W = 16;
  localparam int unsigned STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  // Starvation count for the next cycle: clears unless DMA was denied, and saturates at the limit.
  function automatic logic [STARVE_CNT_W-1:0] starve_next(
    input logic [STARVE_CNT_W-1:0] cnt,
    input logic [STARVE_CNT_W-1:0] limit,
    input logic                    denied
  );
    if (!denied) begin
      return '0;
    end
    if (cnt >= limit) begin
      return limit;
    end
    return cnt + STARVE_CNT_W'(1);
  endfunction

endpackage

// File: rtl/nrisc_data_arbiter.sv
// Two-requester (CPU, DMA) data-memory arbiter with a fixed CPU priority,
// a DMA anti-starvation override and a pipelined read-return path.
module nrisc_data_arbiter
  import nrisc_pkg::*;
#(
  parameter int unsigned ADDR_W       = NRISC_ADDR_W,
  parameter int unsigned DATA_W       = NRISC_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] r_starve_cnt;
  owner_e                  r_owner;
  logic [DATA_W-1:0]       r_cpu_rdata;
  logic [DATA_W-1:0]       r_dma_rdata;

  logic   w_dma_starved;
  logic   w_cpu_gnt;
  logic   w_dma_gnt;
  logic   w_cpu_own;
  logic   w_dma_own;
  owner_e w_owner_nxt;

  // Arbitration: CPU wins ties unless DMA has been denied LIMIT times in a row.
  always_comb begin
    w_dma_starved = (r_starve_cnt == LIMIT);
    w_cpu_gnt     = !rst && cpu_req && !(dma_req && w_dma_starved);
    w_dma_gnt     = !rst && dma_req && !w_cpu_gnt;
  end

  // Memory request mux and the owner of any read issued this cycle.
  always_comb begin
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    w_owner_nxt = OWN_NONE;
    if (w_cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (!cpu_we) begin
        w_owner_nxt = OWN_CPU;
      end
    end else if (w_dma_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      if (!dma_we) begin
        w_owner_nxt = OWN_DMA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_owner      <= OWN_NONE;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
    end else begin
      r_starve_cnt <= starve_next(r_starve_cnt, LIMIT, dma_req && !w_dma_gnt);
      r_owner      <= w_owner_nxt;
      // Capture the returned word so a non-owner cycle keeps showing it.
      if (r_owner == OWN_CPU) begin
        r_cpu_rdata <= mem_rdata;
      end
      if (r_owner == OWN_DMA) begin
        r_dma_rdata <= mem_rdata;
      end
    end
  end

  // Read return: memory data arrives the cycle after the strobe and is steered to the owner.
  always_comb begin
    w_cpu_own  = !rst && (r_owner == OWN_CPU);
    w_dma_own  = !rst && (r_owner == OWN_DMA);
    cpu_gnt    = w_cpu_gnt;
    dma_gnt    = w_dma_gnt;
    cpu_rvalid = w_cpu_own;
    dma_rvalid = w_dma_own;
    cpu_rdata  = '0;
    dma_rdata  = '0;
    if (!rst) begin
      cpu_rdata = w_cpu_own ? mem_rdata : r_cpu_rdata;
      dma_rdata = w_dma_own ? mem_rdata : r_dma_rdata;
    end
  end

endmodule

// File: tb/tb_nrisc_data_arbiter.sv
// Self-checking bench for nrisc_data_arbiter: directed scenarios plus random
// traffic checked against a transaction-level model of arbitration and memory.
module tb_nrisc_data_arbiter;
  import nrisc_pkg::*;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nrisc_data_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous memory attached to the arbiter (256 words, low address byte).
  logic [DW-1:0] mem [256];
  logic          mem_clr, pl_en;
  logic [7:0]    pl_addr;
  logic [DW-1:0] pl_data;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  // Reference model: consecutive-denial count, pending read return, word store.
  logic [DW-1:0] ref_mem [256];
  int            waited;
  int            pend;        // 0 none, 1 cpu, 2 dma
  logic [DW-1:0] pend_data, last_cpu, last_dma;
  logic          e_cg, e_dg, e_en, e_we, e_crv, e_drv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_crd, e_drd;

  task automatic model_eval();
    e_cg = 1'b0; e_dg = 1'b0; e_en = 1'b0; e_we = 1'b0; e_crv = 1'b0; e_drv = 1'b0;
    e_addr = '0; e_wdata = '0; e_crd = '0; e_drd = '0;
    if (!rst) begin
      e_cg = cpu_req && !(dma_req && waited == int'(LIMIT));
      e_dg = dma_req && !e_cg;
      e_en = e_cg || e_dg;
      if (e_cg) begin
        e_we = cpu_we; e_addr = cpu_addr; e_wdata = cpu_wdata;
      end else if (e_dg) begin
        e_we = dma_we; e_addr = dma_addr; e_wdata = dma_wdata;
      end
      e_crv = (pend == 1);
      e_drv = (pend == 2);
      e_crd = e_crv ? pend_data : last_cpu;
      e_drd = e_drv ? pend_data : last_dma;
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      waited = 0; pend = 0; last_cpu = '0; last_dma = '0;
    end else begin
      last_cpu = e_crd;
      last_dma = e_drd;
      pend     = 0;
      if (e_en && e_we) begin
        ref_mem[e_addr[7:0]] = e_wdata;
      end else if (e_en) begin
        pend      = e_cg ? 1 : 2;
        pend_data = ref_mem[e_addr[7:0]];
      end
      waited = (dma_req && !e_dg) ? waited + 1 : 0;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drive_dma(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  task automatic idle();
    drive_cpu(1'b0, 1'b0, '0, '0);
    drive_dma(1'b0, 1'b0, '0, '0);
  endtask

  task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    idle();
    settle();
    advance();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_clr = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    drive_cpu(1'b1, 1'b0, 16'h0010, 16'h5555);
    drive_dma(1'b1, 1'b1, 16'h0020, 16'hAAAA);
    for (int c = 0; c < 3; c++) begin
      settle();
      n_tests++;
      if ({cpu_gnt, dma_gnt, mem_en, mem_we, cpu_rvalid, dma_rvalid, mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs c=%0d gnt=%b%b en=%b we=%b rv=%b%b addr=%h wd=%h crd=%h drd=%h, expected all 0",
                 c, cpu_gnt, dma_gnt, mem_en, mem_we, cpu_rvalid, dma_rvalid, mem_addr, mem_wdata, cpu_rdata, dma_rdata);
      end
      advance();
    end
    rst = 1'b0; mem_clr = 1'b0;
    drive_cpu(1'b1, 1'b1, 16'h00FF, 16'h7777);
    drive_dma(1'b0, 1'b0, '0, '0);
    settle();
    n_tests++;
    if ({cpu_gnt, dma_gnt, mem_en, mem_we} !== 4'b1011) begin
      n_fail++;
      $display("FAIL reset_resume got gnt/en/we=%b%b%b%b expected 1011", cpu_gnt, dma_gnt, mem_en, mem_we);
    end
    advance();
    idle();
  endtask

  task automatic test_cpu_read();
    preload(8'h10, 16'hBEEF);
    drive_cpu(1'b1, 1'b0, 16'h0010, '0);
    settle();
    n_tests++;
    if ({cpu_gnt, dma_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 16'h0010}) begin
      n_fail++;
      $display("FAIL cpu_read_grant got gnt=%b%b en=%b we=%b addr=%h expected 1,0,1,0,0010",
               cpu_gnt, dma_gnt, mem_en, mem_we, mem_addr);
    end
    advance();
    idle();
    settle();
    n_tests++;
    if ({cpu_rvalid, dma_rvalid, cpu_rdata} !== {2'b10, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL cpu_read_return got rv=%b%b rdata=%h expected rv=10 rdata=beef", cpu_rvalid, dma_rvalid, cpu_rdata);
    end
    advance();
    settle();
    n_tests++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b0, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL cpu_read_hold got rv=%b rdata=%h expected rv=0 rdata=beef", cpu_rvalid, cpu_rdata);
    end
    advance();
  endtask

  task automatic test_starvation();
    logic exp_dma;
    drive_dma(1'b1, 1'b1, 16'h0200, 16'hD0D0);
    for (int c = 0; c < 10; c++) begin
      drive_cpu(1'b1, 1'b1, AW'(16'h0100 + c), DW'(c));
      settle();
      exp_dma = (c == 4) || (c == 9);
      n_tests++;
      if ({cpu_gnt, dma_gnt} !== {!exp_dma, exp_dma}) begin
        n_fail++;
        $display("FAIL starve_pattern c=%0d got cpu/dma gnt=%b%b expected %b%b", c, cpu_gnt, dma_gnt, !exp_dma, exp_dma);
      end
      advance();
    end
    idle();
  endtask

  task automatic test_write_then_read();
    drive_dma(1'b1, 1'b1, 16'h0020, 16'h1234);
    settle();
    n_tests++;
    if ({dma_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 16'h0020, 16'h1234}) begin
      n_fail++;
      $display("FAIL wr_rd_write got gnt=%b en=%b we=%b addr=%h wd=%h expected 1,1,1,0020,1234",
               dma_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    advance();
    idle();
    drive_cpu(1'b1, 1'b0, 16'h0020, '0);
    settle();
    n_tests++;
    if ({cpu_gnt, dma_rvalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_rd_grant got cpu_gnt=%b dma_rvalid=%b expected 1,0", cpu_gnt, dma_rvalid);
    end
    advance();
    idle();
    settle();
    n_tests++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 16'h1234}) begin
      n_fail++;
      $display("FAIL wr_rd_return got rv=%b rdata=%h expected 1,1234", cpu_rvalid, cpu_rdata);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    preload(8'h01, 16'hA1A1);
    preload(8'h02, 16'hB2B2);
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i < 4 && (i % 2) == 0) drive_cpu(1'b1, 1'b0, 16'h0001, '0);
      if (i < 4 && (i % 2) == 1) drive_dma(1'b1, 1'b0, 16'h0002, '0);
      settle();
      if (i < 4) begin
        n_tests++;
        if ({cpu_gnt, dma_gnt} !== (((i % 2) == 0) ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL b2b_grant i=%0d got cpu/dma gnt=%b%b", i, cpu_gnt, dma_gnt);
        end
      end
      if (i > 0) begin
        n_tests++;
        if (((i - 1) % 2) == 0) begin
          if ({cpu_rvalid, dma_rvalid, cpu_rdata} !== {2'b10, 16'hA1A1}) begin
            n_fail++;
            $display("FAIL b2b_return i=%0d got rv=%b%b crd=%h expected rv=10 crd=a1a1", i, cpu_rvalid, dma_rvalid, cpu_rdata);
          end
        end else begin
          if ({cpu_rvalid, dma_rvalid, dma_rdata} !== {2'b01, 16'hB2B2}) begin
            n_fail++;
            $display("FAIL b2b_return i=%0d got rv=%b%b drd=%h expected rv=01 drd=b2b2", i, cpu_rvalid, dma_rvalid, dma_rdata);
          end
        end
      end
      advance();
    end
    idle();
  endtask

  task automatic test_reset_mid_read();
    drive_dma(1'b1, 1'b0, 16'h0002, '0);
    settle();
    n_tests++;
    if (dma_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_read_grant got dma_gnt=%b expected 1", dma_gnt);
    end
    advance();
    rst = 1'b1;
    drive_cpu(1'b1, 1'b0, 16'h0001, '0);
    settle();
    n_tests++;
    if ({cpu_gnt, dma_gnt, mem_en, mem_we, cpu_rvalid, dma_rvalid, mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_read gnt=%b%b en=%b we=%b rv=%b%b addr=%h wd=%h crd=%h drd=%h, expected all 0",
               cpu_gnt, dma_gnt, mem_en, mem_we, cpu_rvalid, dma_rvalid, mem_addr, mem_wdata, cpu_rdata, dma_rdata);
    end
    advance();
    rst = 1'b0;
    drive_dma(1'b1, 1'b1, 16'h0030, 16'h3030);
    for (int c = 0; c < 5; c++) begin
      drive_cpu(1'b1, 1'b1, AW'(16'h0040 + c), DW'(c));
      settle();
      n_tests++;
      if ({cpu_gnt, dma_gnt, dma_rvalid} !== ((c == 4) ? 3'b010 : 3'b100)) begin
        n_fail++;
        $display("FAIL rst_starve_cleared c=%0d got cpu/dma gnt=%b%b dma_rvalid=%b", c, cpu_gnt, dma_gnt, dma_rvalid);
      end
      advance();
    end
    idle();
  endtask

  task automatic test_random();
    logic c_pend, d_pend;
    int   dma_wait;
    c_pend = 1'b0; d_pend = 1'b0; dma_wait = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!c_pend) begin
        if ($urandom_range(0, 3) != 0) begin
          drive_cpu(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
          c_pend = 1'b1;
        end else drive_cpu(1'b0, 1'b0, '0, '0);
      end
      if (!d_pend) begin
        if ($urandom_range(0, 2) != 0) begin
          drive_dma(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
          d_pend = 1'b1;
        end else drive_dma(1'b0, 1'b0, '0, '0);
      end
      settle();
      n_tests++;
      if ({cpu_gnt, dma_gnt} !== {e_cg, e_dg}) begin
        n_fail++;
        $display("FAIL rnd_grant cyc=%0d got %b%b expected %b%b", cyc, cpu_gnt, dma_gnt, e_cg, e_dg);
      end
      n_tests++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {e_en, e_we, e_addr, e_wdata}) begin
        n_fail++;
        $display("FAIL rnd_membus cyc=%0d got en=%b we=%b a=%h wd=%h expected en=%b we=%b a=%h wd=%h",
                 cyc, mem_en, mem_we, mem_addr, mem_wdata, e_en, e_we, e_addr, e_wdata);
      end
      n_tests++;
      if ({cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata} !== {e_crv, e_drv, e_crd, e_drd}) begin
        n_fail++;
        $display("FAIL rnd_return cyc=%0d got rv=%b%b crd=%h drd=%h expected rv=%b%b crd=%h drd=%h",
                 cyc, cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata, e_crv, e_drv, e_crd, e_drd);
      end
      n_tests++;
      if ((cpu_gnt && !cpu_req) || (dma_gnt && !dma_req) || (cpu_gnt && dma_gnt)) begin
        n_fail++;
        $display("FAIL rnd_gnt_legal cyc=%0d req=%b%b gnt=%b%b", cyc, cpu_req, dma_req, cpu_gnt, dma_gnt);
      end
      if (dma_req) dma_wait++;
      if (dma_gnt) begin
        n_tests++;
        if (dma_wait > int'(LIMIT) + 1) begin
          n_fail++;
          $display("FAIL rnd_dma_wait cyc=%0d waited=%0d cycles, limit %0d", cyc, dma_wait, LIMIT + 1);
        end
        dma_wait = 0;
      end
      if (cpu_gnt) c_pend = 1'b0;
      if (dma_gnt) d_pend = 1'b0;
      advance();
    end
    idle();
  endtask

  initial begin
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    mem_clr = 1'b1; rst = 1'b1;
    waited = 0; pend = 0; pend_data = '0; last_cpu = '0; last_dma = '0;
    idle();
    test_reset();
    test_cpu_read();
    test_starvation();
    test_write_then_read();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1);
  end

endmodule

// File: doc/nrisc_data_arbiter.md
NRISC_DATA_ARBITER -- requirements
Module: nrisc_data_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, sets the width of the data-memory address.
REQ-002 Parameter DATA_W, default 16, sets the width of the data-memory word.
REQ-003 Parameter STARVE_LIMIT, default 4, is the number of consecutive denied DMA request cycles after which DMA is forced to be granted; legal range 1..15.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cpu_req  in  1  CPU requests an access; held until cpu_gnt.
REQ-007 cpu_we  in  1  1 = write, 0 = read.
REQ-008 cpu_addr  in  ADDR_W  CPU address.
REQ-009 cpu_wdata  in  DATA_W  CPU write data.
REQ-010 cpu_gnt  out  1  CPU access issued to memory this cycle.
REQ-011 cpu_rvalid  out  1  cpu_rdata is valid.
REQ-012 cpu_rdata  out  DATA_W  CPU read data.
REQ-013 dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: same directions, widths and meanings as the cpu_* ports, for the DMA requester.
REQ-014 mem_en  out  1  memory access strobe.
REQ-015 mem_we  out  1  memory write enable.
REQ-016 mem_addr  out  ADDR_W  memory address.
REQ-017 mem_wdata  out  DATA_W  memory write data.
REQ-018 mem_rdata  in  DATA_W  memory read data, valid one cycle after a read strobe.

Function
REQ-019 The block SHALL issue at most one memory access per cycle; gnt, mem_en, mem_we, mem_addr and mem_wdata SHALL be combinational from the requests and the registered state.
REQ-020 If only one requester asserts req, that requester SHALL be granted in the same cycle.
REQ-021 If both requesters assert req, CPU SHALL win, except when starve_cnt == STARVE_LIMIT, in which case DMA SHALL win.
REQ-022 starve_cnt (4-bit) SHALL increment when dma_req=1 and dma_gnt=0, SHALL clear on dma_gnt=1 or dma_req=0, and SHALL saturate at STARVE_LIMIT.
REQ-023 With no grant: mem_en=0 and mem_we=0; mem_addr and mem_wdata SHALL be driven 0.
REQ-024 A granted read SHALL load a registered owner field in {NONE, CPU, DMA}; the cycle after, the owner's rvalid SHALL be 1 and its rdata SHALL equal mem_rdata, for exactly one cycle.
REQ-025 The rdata of a non-owner SHALL hold its last value; rvalid SHALL never be asserted for writes.
REQ-026 Back-to-back reads SHALL be pipelined at one per cycle with no bubble, including reads that alternate between owners.
REQ-027 A write followed by a read of the same address SHALL return the written data; the block SHALL add no forwarding.
REQ-028 gnt SHALL never be 1 while the corresponding req is 0, and cpu_gnt and dma_gnt SHALL never both be 1.

Reset
REQ-029 While rst=1: all gnt and mem_* outputs SHALL be 0, rvalid SHALL be 0, rdata SHALL be 0, starve_cnt SHALL be 0, and owner SHALL be NONE.
REQ-030 A read granted in the cycle before rst SHALL produce no rvalid.
REQ-031 Arbitration SHALL resume in the first cycle after rst deasserts.

Structure
REQ-032 The owner enum {OWN_NONE, OWN_CPU, OWN_DMA} and the default ADDR_W/DATA_W constants SHALL reside in the shared package nrisc_pkg.
REQ-033 The block SHALL be a single module with no sub-module; the starve counter and owner register SHALL be inline.

Verification
REQ-034 CPU read 0x0010 alone, memory returns 0xBEEF -> cpu_gnt in cycle 0, cpu_rvalid=1 with rdata=0xBEEF in cycle 1, dma_rvalid=0.
REQ-035 CPU and DMA requests held for 10 cycles with STARVE_LIMIT=4 -> cpu_gnt in cycles 0-3, dma_gnt in cycle 4, cpu_gnt in cycles 5-8, dma_gnt in cycle 9.
REQ-036 DMA write 0x1234 to 0x0020 followed by a CPU read of 0x0020 in the next cycle -> CPU receives 0x1234 one cycle after its grant.
REQ-037 Alternating CPU read of 0x0001 and DMA read of 0x0002 on consecutive cycles -> each rvalid is routed to the correct owner with no bubble.
REQ-038 rst asserted the cycle after a granted DMA read -> no dma_rvalid, all outputs 0, starve_cnt=0.
REQ-039 Random req/we traffic over 10k cycles -> assertions on REQ-028 hold and no DMA wait exceeds STARVE_LIMIT+1 cycles.
